flt_norm_store: RTL
===================

FLT_NORM_STORE -- requirements
Module: flt_norm_store

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 8'd132; data-memory byte address of result MSB (LSB at ADDR_BASE+1).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  unnormalized sum from adder core present.
REQ-005 SHALL have port in_ready  output  1  block idle, will accept in_valid.
REQ-006 SHALL have port in_sign  input  1  result sign.
REQ-007 SHALL have port in_exp  input  7  signed biased exponent, weighted at in_mant[13].
REQ-008 SHALL have port in_mant  input  15  [14] carry, [13] hidden, [12:3] fraction, [2] guard, [1] round, [0] sticky.
REQ-009 SHALL have port mem_we  output  1  data-memory byte write strobe.
REQ-010 SHALL have port mem_addr  output  8  write address.
REQ-011 SHALL have port mem_wdata  output  8  write byte.
REQ-012 SHALL have port done  output  1  result stored in memory.

Function
REQ-013 SHALL accept the input (register sign/exp/mant) in cycle T when in_valid and in_ready are both high; in_valid while in_ready low is ignored.
REQ-014 SHALL implement FSM IDLE -> NORM -> ROUND -> WR_HI -> WR_LO -> DONE; DONE -> NORM on accepted in_valid; in_ready high only in IDLE and DONE.
REQ-015 NORM, one action per cycle: mant==0 -> force +0, go ROUND; mant[14]==1 -> shift right 1, exp+1, sticky|=shifted-out bit; mant[13]==0 -> shift left 1, exp-1; else go ROUND.
REQ-016 ROUND SHALL apply round-to-nearest-even: increment fraction iff guard & (round | sticky | fraction[0]); a carry into bit14 SHALL renormalize (shift right, exp+1) in the same cycle.
REQ-017 After rounding, exp >= 31 SHALL produce {sign, 5'h1F, 10'h000}; exp <= 0 SHALL produce 16'h0000; otherwise {sign, exp[4:0], fraction}.
REQ-018 WR_HI SHALL drive mem_we=1, mem_addr=ADDR_BASE, mem_wdata=result[15:8]; WR_LO SHALL drive ADDR_BASE+1, result[7:0].
REQ-019 mem_we SHALL be high only in WR_HI and WR_LO; mem_addr/mem_wdata are don't-care otherwise.
REQ-020 done SHALL be high exactly in DONE, held until the next accepted input or reset.
REQ-021 Latency: normalized input (no shifts) -> WR_HI at T+3, WR_LO at T+4, done at T+5; each NORM shift adds one cycle.
REQ-022 Exponent arithmetic SHALL be 7-bit signed; left shifts beyond exp -64 are unreachable given a 5-bit source and are not checked.

Reset
REQ-023 reset SHALL force state IDLE, in_ready=1, done=0, mem_we=0, internal registers to 0.
REQ-024 reset mid-operation SHALL abort with no further mem_we; a pending WR_LO SHALL NOT occur.

Structure
REQ-025 Package flt_pkg SHALL hold the state enum, BIAS=15, EXP_MAX=31, field widths/positions of in_mant.
REQ-026 Rounding SHALL be a combinational sub-module flt_round_rne (mant in, rounded mant + carry out); everything else in flt_norm_store.

Verification
REQ-027 Carry: sign 0, exp 6, mant 15'h6040 -> mem[132]=8'h1E, mem[133]=8'h04, done at T+6.
REQ-028 Normalized: exp 16, mant 15'h2000 -> 16'h4000, WR_HI at T+3, done at T+5; exp 16, mant 15'h2004 (tie, even) -> 16'h4000; mant 15'h200C (tie, odd) -> 16'h4002.
REQ-029 Left shift and zero: exp 16, mant 15'h0800 -> 16'h3800, done at T+7; mant 15'h0000, sign 1 -> 16'h0000.
REQ-030 Overflow/underflow: sign 1, exp 31, mant 15'h2000 -> 16'hFC00; exp 16, mant 15'h3FFC -> rounds to 16'h4400; exp 0, mant 15'h2000 -> 16'h0000.
REQ-031 Reset at T+3 (during WR_HI) -> no mem_we from T+4, done=0, in_ready=1 at T+4; in_valid held during busy cycles ignored.

Source files
------------

// File: rtl/flt_pkg.sv
// Shared types and constants for the half-precision normalize/round/store path.
// Field positions describe the adder core's unnormalized mantissa layout.
package flt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NORM,
        ST_ROUND,
        ST_WR_HI,
        ST_WR_LO,
        ST_DONE
    } state_t;

    localparam int BIAS       = 15;
    localparam int MANT_W     = 15;
    localparam int EXP_W      = 7;
    localparam int FRAC_W     = 10;
    localparam int CARRY_BIT  = 14;
    localparam int HIDDEN_BIT = 13;
    localparam int FRAC_MSB   = 12;
    localparam int FRAC_LSB   = 3;
    localparam int GUARD_BIT  = 2;
    localparam int ROUND_BIT  = 1;
    localparam int STICKY_BIT = 0;

    localparam logic signed [EXP_W-1:0] EXP_MAX = 7'sd31;
    localparam logic signed [EXP_W-1:0] EXP_MIN = 7'sd0;

    typedef struct packed {
        logic                    sign;
        logic signed [EXP_W-1:0] exp;
        logic [MANT_W-1:0]       mant;
    } operand_t;

endpackage

// File: rtl/flt_round_rne.sv
// Round-to-nearest-even on a normalized mantissa; returns hidden+fraction and carry.
// Latency: combinational. Backpressure: none.
// Input bit 14 is expected clear, so carry means the increment overflowed the hidden bit.
module flt_round_rne
    import flt_pkg::*;
(
    input  logic [MANT_W-1:0] mant,
    output logic [FRAC_W:0]   frac_rnd,
    output logic              carry
);

    logic       inc;
    logic [11:0] upper;

    always_comb begin
        inc      = mant[GUARD_BIT] & (mant[ROUND_BIT] | mant[STICKY_BIT] | mant[FRAC_LSB]);
        upper    = mant[CARRY_BIT:FRAC_LSB] + {11'd0, inc};
        frac_rnd = upper[FRAC_W:0];
        carry    = upper[11];
    end

endmodule

// File: rtl/flt_norm_store.sv
// Normalizes, rounds and packs an adder sum to binary16, then writes it as two bytes.
// Latency: done at T+5 for a normalized input, +1 cycle per normalization shift.
// Backpressure: in_ready only in IDLE/DONE; in_valid while busy is ignored.
module flt_norm_store
    import flt_pkg::*;
#(
    parameter logic [7:0] ADDR_BASE = 8'd132
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [6:0]  in_exp,
    input  logic [14:0] in_mant,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        done
);

    state_t   state, state_nxt;
    operand_t op, op_nxt;
    logic [15:0] result, result_nxt;

    logic [FRAC_W:0]         frac_rnd;
    logic                    rnd_carry;
    logic signed [EXP_W-1:0] exp_fin;
    logic [FRAC_W-1:0]       frac_fin;

    flt_round_rne u_round (
        .mant     (op.mant),
        .frac_rnd (frac_rnd),
        .carry    (rnd_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            op     <= '0;
            result <= '0;
        end else begin
            state  <= state_nxt;
            op     <= op_nxt;
            result <= result_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        op_nxt     = op;
        result_nxt = result;
        in_ready   = 1'b0;
        done       = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = ADDR_BASE;
        mem_wdata  = result[15:8];

        // A rounding carry leaves 1.000..., so shifting the fraction right is exact.
        exp_fin  = op.exp + {6'd0, rnd_carry};
        frac_fin = rnd_carry ? frac_rnd[FRAC_W:1] : frac_rnd[FRAC_W-1:0];

        case (state)
            ST_IDLE, ST_DONE: begin
                in_ready = 1'b1;
                done     = (state == ST_DONE);
                if (in_valid) begin
                    op_nxt    = '{sign: in_sign, exp: in_exp, mant: in_mant};
                    state_nxt = ST_NORM;
                end
            end
            ST_NORM: begin
                if (op.mant == '0) begin
                    op_nxt    = '0;
                    state_nxt = ST_ROUND;
                end else if (op.mant[CARRY_BIT]) begin
                    op_nxt.mant = {1'b0, op.mant[CARRY_BIT:2], op.mant[1] | op.mant[0]};
                    op_nxt.exp  = op.exp + 7'sd1;
                end else if (!op.mant[HIDDEN_BIT]) begin
                    op_nxt.mant = {op.mant[MANT_W-2:0], 1'b0};
                    op_nxt.exp  = op.exp - 7'sd1;
                end else begin
                    state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (exp_fin >= EXP_MAX) begin
                    result_nxt = {op.sign, 5'h1F, 10'h000};
                end else if (exp_fin <= EXP_MIN) begin
                    result_nxt = 16'h0000;
                end else begin
                    result_nxt = {op.sign, exp_fin[4:0], frac_fin};
                end
                state_nxt = ST_WR_HI;
            end
            ST_WR_HI: begin
                mem_we    = 1'b1;
                state_nxt = ST_WR_LO;
            end
            ST_WR_LO: begin
                mem_we    = 1'b1;
                mem_addr  = ADDR_BASE + 8'd1;
                mem_wdata = result[7:0];
                state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
